// File: rtl/idli_sqi_seq_m.sv
// SQI burst sequencer: core read/write bursts to nibble-split SQI pin sequences.
// Optional IDLI_SQI_SEQ_INIT_EN: issue EQIO in SPI mode after reset before IDLE.
module idli_sqi_seq_m #(
    parameter int unsigned LEN_W  = 4,
    parameter logic [7:0]  CMD_RD = 8'h03,
    parameter logic [7:0]  CMD_WR = 8'h02
) (
    input  logic             i_sqi_gck,
    input  logic             i_sqi_rst,
    input  logic             i_req_vld,
    output logic             o_req_rdy,
    input  logic             i_req_wr,
    input  logic [15:0]      i_req_addr,
    input  logic [LEN_W-1:0] i_req_cnt,
    input  logic             i_wdata_vld,
    input  logic [15:0]      i_wdata,
    output logic             o_wdata_rdy,
    output logic             o_rdata_vld,
    output logic [15:0]      o_rdata,
    output logic             o_cs_n,
    output logic             o_sck_en,
    output logic             o_sio_oe,
    output logic [3:0]       o_sio_hi,
    output logic [3:0]       o_sio_lo,
    input  logic [3:0]       i_sio_hi,
    input  logic [3:0]       i_sio_lo
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CMD   = 3'd1;
    localparam logic [2:0] ST_ADDR  = 3'd2;
    localparam logic [2:0] ST_DUMMY = 3'd3;
    localparam logic [2:0] ST_DATA  = 3'd4;
    localparam logic [2:0] ST_END   = 3'd5;
`ifdef IDLI_SQI_SEQ_INIT_EN
    localparam logic [2:0] ST_INIT  = 3'd6;
    localparam logic [7:0] CMD_EQIO = 8'h38;
`endif

    logic [2:0]       state, n_state;
    logic [2:0]       ph, n_ph;
    logic [LEN_W-1:0] cnt, n_cnt;
    logic             wr, n_wr;
    logic [15:0]      addr, n_addr;
    logic [7:0]       wbuf, n_wbuf;
    logic [7:0]       hold;
    logic             n_req_rdy, n_wdata_rdy, n_cs_n, n_sck_en, n_sio_oe;
    logic [3:0]       n_sio_hi, n_sio_lo, nib;
    logic [23:0]      baddr;
    logic [7:0]       cmd;
    logic             stall;

    // Outputs are computed for the state being entered so they register alongside it.
    always_comb begin
        n_state     = state;
        n_ph        = ph;
        n_cnt       = cnt;
        n_wr        = wr;
        n_addr      = addr;
        n_wbuf      = wbuf;
        n_req_rdy   = 1'b0;
        n_wdata_rdy = 1'b0;
        n_cs_n      = 1'b1;
        n_sck_en    = 1'b0;
        n_sio_oe    = 1'b0;
        n_sio_hi    = '0;
        n_sio_lo    = '0;
        nib         = '0;
        baddr       = '0;
        cmd         = '0;
        stall       = o_wdata_rdy && !i_wdata_vld;

        if (stall) begin
            // Write word missing: freeze the sequence with SCK gated off.
            n_wdata_rdy = 1'b1;
            n_cs_n      = 1'b0;
            n_sio_oe    = 1'b1;
            n_sio_hi    = o_sio_hi;
            n_sio_lo    = o_sio_lo;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (o_req_rdy && i_req_vld) begin
                        n_state = ST_CMD;
                        n_ph    = '0;
                        n_wr    = i_req_wr;
                        n_addr  = i_req_addr;
                        n_cnt   = i_req_cnt;
                    end
`ifdef IDLI_SQI_SEQ_INIT_EN
                    else if (!o_req_rdy) begin
                        n_state = ST_INIT;
                        n_ph    = '0;
                    end
`endif
                end
                ST_CMD: begin
                    if (ph == 3'd0) n_ph = 3'd1;
                    else begin
                        n_state = ST_ADDR;
                        n_ph    = '0;
                    end
                end
                ST_ADDR: begin
                    if (ph != 3'd5) n_ph = ph + 3'd1;
                    else begin
                        n_state = wr ? ST_DATA : ST_DUMMY;
                        n_ph    = '0;
                    end
                end
                ST_DUMMY: begin
                    if (ph == 3'd0) n_ph = 3'd1;
                    else begin
                        n_state = ST_DATA;
                        n_ph    = '0;
                    end
                end
                ST_DATA: begin
                    if (ph == 3'd0) n_ph = 3'd1;
                    else if (cnt == '0) begin
                        n_state = ST_END;
                        n_ph    = '0;
                    end else begin
                        n_ph  = '0;
                        n_cnt = cnt - 1'b1;
                    end
                end
`ifdef IDLI_SQI_SEQ_INIT_EN
                ST_INIT: begin
                    if (ph != 3'd7) n_ph = ph + 3'd1;
                    else begin
                        n_state = ST_END;
                        n_ph    = '0;
                    end
                end
`endif
                ST_END:  n_state = ST_IDLE;
                default: n_state = ST_IDLE;
            endcase

            baddr = {7'b0, n_addr, 1'b0};
            cmd   = n_wr ? CMD_WR : CMD_RD;

            case (n_state)
                ST_IDLE: n_req_rdy = 1'b1;
                ST_CMD: begin
                    n_cs_n   = 1'b0;
                    n_sck_en = 1'b1;
                    n_sio_oe = 1'b1;
                    nib      = n_ph[0] ? cmd[3:0] : cmd[7:4];
                    n_sio_hi = nib;
                    n_sio_lo = nib;
                end
                ST_ADDR: begin
                    n_cs_n   = 1'b0;
                    n_sck_en = 1'b1;
                    n_sio_oe = 1'b1;
                    case (n_ph)
                        3'd0:    nib = baddr[23:20];
                        3'd1:    nib = baddr[19:16];
                        3'd2:    nib = baddr[15:12];
                        3'd3:    nib = baddr[11:8];
                        3'd4:    nib = baddr[7:4];
                        default: nib = baddr[3:0];
                    endcase
                    n_sio_hi    = nib;
                    n_sio_lo    = nib;
                    n_wdata_rdy = n_wr && (n_ph == 3'd5);
                end
                ST_DUMMY: begin
                    n_cs_n   = 1'b0;
                    n_sck_en = 1'b1;
                end
                ST_DATA: begin
                    n_cs_n   = 1'b0;
                    n_sck_en = 1'b1;
                    n_sio_oe = n_wr;
                    if (n_wr) begin
                        if (n_ph == 3'd0) begin
                            n_sio_hi = i_wdata[15:12];
                            n_sio_lo = i_wdata[11:8];
                            n_wbuf   = i_wdata[7:0];
                        end else begin
                            n_sio_hi = wbuf[7:4];
                            n_sio_lo = wbuf[3:0];
                        end
                        n_wdata_rdy = (n_ph == 3'd1) && (n_cnt != '0);
                    end
                end
`ifdef IDLI_SQI_SEQ_INIT_EN
                ST_INIT: begin
                    n_cs_n   = 1'b0;
                    n_sck_en = 1'b1;
                    n_sio_oe = 1'b1;
                    n_sio_hi = {3'b0, CMD_EQIO[3'd7 - n_ph]};
                    n_sio_lo = {3'b0, CMD_EQIO[3'd7 - n_ph]};
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_sqi_gck) begin
        if (i_sqi_rst) begin
            state       <= ST_IDLE;
            ph          <= '0;
            cnt         <= '0;
            wr          <= 1'b0;
            addr        <= '0;
            wbuf        <= '0;
            hold        <= '0;
            o_req_rdy   <= 1'b0;
            o_wdata_rdy <= 1'b0;
            o_rdata_vld <= 1'b0;
            o_rdata     <= '0;
            o_cs_n      <= 1'b1;
            o_sck_en    <= 1'b0;
            o_sio_oe    <= 1'b0;
            o_sio_hi    <= '0;
            o_sio_lo    <= '0;
        end else begin
            state       <= n_state;
            ph          <= n_ph;
            cnt         <= n_cnt;
            wr          <= n_wr;
            addr        <= n_addr;
            wbuf        <= n_wbuf;
            o_req_rdy   <= n_req_rdy;
            o_wdata_rdy <= n_wdata_rdy;
            o_cs_n      <= n_cs_n;
            o_sck_en    <= n_sck_en;
            o_sio_oe    <= n_sio_oe;
            o_sio_hi    <= n_sio_hi;
            o_sio_lo    <= n_sio_lo;
            o_rdata_vld <= 1'b0;
            // Read bytes are sampled at the edge closing each DATA cycle.
            if (state == ST_DATA && !wr) begin
                if (ph == 3'd0) begin
                    hold <= {i_sio_hi, i_sio_lo};
                end else begin
                    o_rdata     <= {hold, i_sio_hi, i_sio_lo};
                    o_rdata_vld <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_idli_sqi_seq_m.sv
// Cycle-accurate bench for idli_sqi_seq_m; honours IDLI_SQI_SEQ_INIT_EN if defined.
module tb_idli_sqi_seq_m;

    logic        clk = 1'b0;
    logic        i_sqi_rst = 1'b1;
    logic        i_req_vld = 1'b0;
    logic        o_req_rdy;
    logic        i_req_wr = 1'b0;
    logic [15:0] i_req_addr = '0;
    logic [3:0]  i_req_cnt = '0;
    logic        i_wdata_vld = 1'b0;
    logic [15:0] i_wdata = '0;
    logic        o_wdata_rdy;
    logic        o_rdata_vld;
    logic [15:0] o_rdata;
    logic        o_cs_n, o_sck_en, o_sio_oe;
    logic [3:0]  o_sio_hi, o_sio_lo;
    logic [3:0]  i_sio_hi = '0;
    logic [3:0]  i_sio_lo = '0;

    always #5 clk = ~clk;

    idli_sqi_seq_m #(.LEN_W(4), .CMD_RD(8'h03), .CMD_WR(8'h02)) dut (
        .i_sqi_gck(clk), .i_sqi_rst(i_sqi_rst),
        .i_req_vld(i_req_vld), .o_req_rdy(o_req_rdy), .i_req_wr(i_req_wr),
        .i_req_addr(i_req_addr), .i_req_cnt(i_req_cnt),
        .i_wdata_vld(i_wdata_vld), .i_wdata(i_wdata), .o_wdata_rdy(o_wdata_rdy),
        .o_rdata_vld(o_rdata_vld), .o_rdata(o_rdata),
        .o_cs_n(o_cs_n), .o_sck_en(o_sck_en), .o_sio_oe(o_sio_oe),
        .o_sio_hi(o_sio_hi), .o_sio_lo(o_sio_lo),
        .i_sio_hi(i_sio_hi), .i_sio_lo(i_sio_lo)
    );

    // One record per DUT cycle: what the bench drives, and what the pins must show.
    typedef struct {
        logic        cs_n, sck, oe, wrdy, rvld, rrdy, chk;
        logic [3:0]  hi, lo;
        logic [15:0] rdata;
        logic        wvld;
        logic [15:0] wdat;
        logic [3:0]  shi, slo;
    } cyc_t;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [3:0]  cnt;
        int          sw;
        int          sn;
    } tx_t;

    cyc_t        exp_q[$];
    cyc_t        tbl1[14];
    tx_t         txs[5];
    logic [15:0] wr_words[16];
    logic [15:0] rd_words[16];
    int          n_vec = 0;
    int          n_miss = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic cyc_t blank();
        cyc_t e;
        e.cs_n = 1'b0; e.sck = 1'b1; e.oe = 1'b1; e.wrdy = 1'b0; e.rvld = 1'b0; e.rrdy = 1'b0;
        e.chk = 1'b0; e.hi = '0; e.lo = '0; e.rdata = '0;
        e.wvld = 1'b1; e.wdat = 16'($urandom); e.shi = 4'($urandom); e.slo = 4'($urandom);
        return e;
    endfunction

    function automatic cyc_t mkc(input logic [5:0] f, input logic c, input logic [3:0] hi,
                                 input logic [3:0] lo, input logic [3:0] shi, input logic [3:0] slo,
                                 input logic [15:0] rd);
        cyc_t e;
        {e.cs_n, e.sck, e.oe, e.wrdy, e.rvld, e.rrdy} = f;
        e.chk = c; e.hi = hi; e.lo = lo; e.shi = shi; e.slo = slo; e.rdata = rd;
        e.wvld = 1'b0; e.wdat = '0;
        return e;
    endfunction

    task automatic apply_cycle(input cyc_t e, input string tag);
        chk($sformatf("%s cs_n", tag), 16'(o_cs_n), 16'(e.cs_n));
        chk($sformatf("%s sck_en", tag), 16'(o_sck_en), 16'(e.sck));
        chk($sformatf("%s sio_oe", tag), 16'(o_sio_oe), 16'(e.oe));
        chk($sformatf("%s wdata_rdy", tag), 16'(o_wdata_rdy), 16'(e.wrdy));
        chk($sformatf("%s rdata_vld", tag), 16'(o_rdata_vld), 16'(e.rvld));
        chk($sformatf("%s req_rdy", tag), 16'(o_req_rdy), 16'(e.rrdy));
        if (e.chk) begin
            chk($sformatf("%s sio_hi", tag), 16'(o_sio_hi), 16'(e.hi));
            chk($sformatf("%s sio_lo", tag), 16'(o_sio_lo), 16'(e.lo));
        end
        if (e.rvld) chk($sformatf("%s rdata", tag), o_rdata, e.rdata);
        i_wdata_vld = e.wvld;
        i_wdata     = e.wdat;
        i_sio_hi    = e.shi;
        i_sio_lo    = e.slo;
    endtask

    task automatic check_reset(input string tag);
        chk($sformatf("%s cs_n", tag), 16'(o_cs_n), 16'h1);
        chk($sformatf("%s sck_en", tag), 16'(o_sck_en), 16'h0);
        chk($sformatf("%s sio_oe", tag), 16'(o_sio_oe), 16'h0);
        chk($sformatf("%s sio_hi", tag), 16'(o_sio_hi), 16'h0);
        chk($sformatf("%s sio_lo", tag), 16'(o_sio_lo), 16'h0);
        chk($sformatf("%s req_rdy", tag), 16'(o_req_rdy), 16'h0);
        chk($sformatf("%s wdata_rdy", tag), 16'(o_wdata_rdy), 16'h0);
        chk($sformatf("%s rdata_vld", tag), 16'(o_rdata_vld), 16'h0);
        chk($sformatf("%s rdata", tag), o_rdata, 16'h0);
    endtask

    // Called on the first cycle after reset is released.
    task automatic check_boot();
`ifdef IDLI_SQI_SEQ_INIT_EN
        logic [7:0] eqio;
        eqio = 8'h38;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("init%0d cs_n", k), 16'(o_cs_n), 16'h0);
            chk($sformatf("init%0d sck_en", k), 16'(o_sck_en), 16'h1);
            chk($sformatf("init%0d sio_oe", k), 16'(o_sio_oe), 16'h1);
            chk($sformatf("init%0d req_rdy", k), 16'(o_req_rdy), 16'h0);
            chk($sformatf("init%0d sio_hi", k), 16'(o_sio_hi), 16'({3'b0, eqio[7-k]}));
            chk($sformatf("init%0d sio_lo", k), 16'(o_sio_lo), 16'({3'b0, eqio[7-k]}));
            step();
        end
        chk("init end cs_n", 16'(o_cs_n), 16'h1);
        chk("init end req_rdy", 16'(o_req_rdy), 16'h0);
        step();
`endif
        chk("boot req_rdy", 16'(o_req_rdy), 16'h1);
    endtask

    task automatic start_req(input logic wr, input logic [15:0] addr, input logic [3:0] cnt);
        int t;
        t = 0;
        while (!o_req_rdy && t < 50) begin
            step();
            t++;
        end
        chk("req_rdy wait", 16'(o_req_rdy), 16'h1);
        i_req_vld  = 1'b1;
        i_req_wr   = wr;
        i_req_addr = addr;
        i_req_cnt  = cnt;
        step();
        i_req_vld  = 1'b0;
    endtask

    // Expected cycle sequence of one burst, from CMD through the following IDLE cycle.
    task automatic build(input logic wr, input logic [15:0] addr, input logic [3:0] cnt,
                         input int sw, input int sn);
        logic [23:0] ba;
        logic [7:0]  cmd;
        logic        p_v;
        logic [15:0] p_d;
        cyc_t        e;
        ba  = {7'b0, addr, 1'b0};
        cmd = wr ? 8'h02 : 8'h03;
        p_v = 1'b0;
        p_d = '0;
        for (int i = 0; i < 2; i++) begin
            e = blank(); e.chk = 1'b1;
            e.hi = (i == 0) ? cmd[7:4] : cmd[3:0]; e.lo = e.hi;
            exp_q.push_back(e);
        end
        for (int i = 0; i < 6; i++) begin
            e = blank(); e.chk = 1'b1;
            e.hi = ba[23-4*i -: 4]; e.lo = e.hi;
            if (i == 5 && wr) begin
                e.wrdy = 1'b1; e.wdat = wr_words[0]; e.wvld = !(sn > 0 && sw == 0);
            end
            exp_q.push_back(e);
        end
        if (!wr) begin
            for (int i = 0; i < 2; i++) begin
                e = blank(); e.oe = 1'b0;
                exp_q.push_back(e);
            end
        end
        for (int w = 0; w <= int'(cnt); w++) begin
            if (wr && sn > 0 && sw == w) begin
                for (int k = 0; k < sn; k++) begin
                    e = blank(); e.sck = 1'b0; e.wrdy = 1'b1; e.chk = 1'b1;
                    e.hi = exp_q[$].hi; e.lo = exp_q[$].lo;
                    e.wvld = (k == sn - 1); e.wdat = wr_words[w];
                    exp_q.push_back(e);
                end
            end
            e = blank();
            e.rvld = p_v; e.rdata = p_d; p_v = 1'b0;
            if (wr) begin
                e.chk = 1'b1; e.hi = wr_words[w][15:12]; e.lo = wr_words[w][11:8];
            end else begin
                e.oe = 1'b0; e.shi = rd_words[w][15:12]; e.slo = rd_words[w][11:8];
            end
            exp_q.push_back(e);
            e = blank();
            if (wr) begin
                e.chk = 1'b1; e.hi = wr_words[w][7:4]; e.lo = wr_words[w][3:0];
                if (w < int'(cnt)) begin
                    e.wrdy = 1'b1; e.wdat = wr_words[w+1]; e.wvld = !(sn > 0 && sw == w + 1);
                end
            end else begin
                e.oe = 1'b0; e.shi = rd_words[w][7:4]; e.slo = rd_words[w][3:0];
                p_v = 1'b1; p_d = rd_words[w];
            end
            exp_q.push_back(e);
        end
        e = blank(); e.cs_n = 1'b1; e.sck = 1'b0; e.oe = 1'b0; e.rvld = p_v; e.rdata = p_d;
        exp_q.push_back(e);
        e = blank(); e.cs_n = 1'b1; e.sck = 1'b0; e.oe = 1'b0; e.rrdy = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic run_q(input int n, input string tag);
        int i;
        cyc_t e;
        i = 0;
        while (exp_q.size() > 0 && (n < 0 || i < n)) begin
            e = exp_q.pop_front();
            apply_cycle(e, $sformatf("%s c%0d", tag, i));
            step();
            i++;
        end
    endtask

    initial begin
        cyc_t e;
        // Read of 16'h1234, one word: memory returns A/B then C/D.
        tbl1[0]  = mkc(6'b011000, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0);
        tbl1[1]  = mkc(6'b011000, 1'b1, 4'h3, 4'h3, 4'h0, 4'h0, 16'h0);
        tbl1[2]  = mkc(6'b011000, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0);
        tbl1[3]  = mkc(6'b011000, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0);
        tbl1[4]  = mkc(6'b011000, 1'b1, 4'h2, 4'h2, 4'h0, 4'h0, 16'h0);
        tbl1[5]  = mkc(6'b011000, 1'b1, 4'h4, 4'h4, 4'h0, 4'h0, 16'h0);
        tbl1[6]  = mkc(6'b011000, 1'b1, 4'h6, 4'h6, 4'h0, 4'h0, 16'h0);
        tbl1[7]  = mkc(6'b011000, 1'b1, 4'h8, 4'h8, 4'h0, 4'h0, 16'h0);
        tbl1[8]  = mkc(6'b010000, 1'b0, 4'h0, 4'h0, 4'h5, 4'h5, 16'h0);
        tbl1[9]  = mkc(6'b010000, 1'b0, 4'h0, 4'h0, 4'h5, 4'h5, 16'h0);
        tbl1[10] = mkc(6'b010000, 1'b0, 4'h0, 4'h0, 4'hA, 4'hB, 16'h0);
        tbl1[11] = mkc(6'b010000, 1'b0, 4'h0, 4'h0, 4'hC, 4'hD, 16'h0);
        tbl1[12] = mkc(6'b100010, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 16'hABCD);
        tbl1[13] = mkc(6'b100001, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0);

        txs[0] = '{1'b1, 16'h0001, 4'd1, 0, 0};
        txs[1] = '{1'b1, 16'h0001, 4'd1, 1, 3};
        txs[2] = '{1'b0, 16'h4000, 4'd15, 0, 0};
        txs[3] = '{1'b1, 16'hFFFF, 4'd2, 0, 1};
        txs[4] = '{1'b0, 16'hFFFF, 4'd1, 0, 0};

        repeat (3) step();
        check_reset("reset");
        i_sqi_rst = 1'b0;
        step();
        check_boot();

        start_req(1'b0, 16'h1234, 4'd0);
        for (int i = 0; i < 14; i++) begin
            apply_cycle(tbl1[i], $sformatf("rd1234 c%0d", i));
            step();
        end

        for (int t = 0; t < 5; t++) begin
            for (int w = 0; w < 16; w++) begin
                wr_words[w] = 16'($urandom);
                rd_words[w] = 16'($urandom);
            end
            wr_words[0] = 16'h5A3C;
            wr_words[1] = 16'hF00F;
            build(txs[t].wr, txs[t].addr, txs[t].cnt, txs[t].sw, txs[t].sn);
            start_req(txs[t].wr, txs[t].addr, txs[t].cnt);
            run_q(-1, $sformatf("tx%0d", t));
        end

        // Reset during the third DATA cycle of a read burst.
        for (int w = 0; w < 16; w++) rd_words[w] = 16'($urandom);
        build(1'b0, 16'h0100, 4'd3, 0, 0);
        start_req(1'b0, 16'h0100, 4'd3);
        run_q(12, "abort");
        e = exp_q.pop_front();
        apply_cycle(e, "abort c12");
        i_sqi_rst = 1'b1;
        step();
        exp_q.delete();
        check_reset("abort rst");
        i_sqi_rst = 1'b0;
        step();
        check_boot();

        rd_words[0] = 16'h1357;
        build(1'b0, 16'h00FF, 4'd0, 0, 0);
        start_req(1'b0, 16'h00FF, 4'd0);
        run_q(-1, "recover");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/idli_sqi_seq_m.md
Name: idli_sqi_seq_m

Overview:
Transaction sequencer directly upstream of the SQI pin interface. Turns core burst requests (read/write, 16-bit word address, word count) into the per-cycle SQI command/address/dummy/data nibble sequence and chip-select/output-enable/clock-enable controls for the two nibble-split memories. It also assembles returned nibbles into 16-bit words.
- Memory 1 holds the high nibble of every byte; memory 0 holds the low nibble.
- One byte is transferred per SQI cycle, so one word takes 2 cycles.

Parameters:
LEN_W, 4, width of burst count field; a burst is i_req_cnt+1 words (1..2^LEN_W).
CMD_RD, 8'h03, SQI read command byte.
CMD_WR, 8'h02, SQI write command byte.

Ports:
i_sqi_gck  in  1  clock; all logic on rising edge.
i_sqi_rst  in  1  synchronous active-high reset.
i_req_vld  in  1  request valid.
o_req_rdy  out  1  request accepted when vld&rdy.
i_req_wr  in  1  1=write, 0=read.
i_req_addr  in  16  starting word address.
i_req_cnt  in  LEN_W  word count minus one.
i_wdata_vld  in  1  write word valid.
i_wdata  in  16  write word.
o_wdata_rdy  out  1  write word consumed when vld&rdy.
o_rdata_vld  out  1  read word valid (one-cycle pulse, no backpressure).
o_rdata  out  16  read word.
o_cs_n  out  1  chip select to both memories, active low.
o_sck_en  out  1  SCK gate; memories clocked only when 1.
o_sio_oe  out  1  1 = drive SIO, 0 = sample.
o_sio_hi  out  4  nibble driven to memory 1.
o_sio_lo  out  4  nibble driven to memory 0.
i_sio_hi  in  4  nibble from memory 1.
i_sio_lo  in  4  nibble from memory 0.

Behaviour:
- All outputs are registered.
- Reset values: o_cs_n=1; o_sck_en=0; o_sio_oe=0; o_sio_hi/lo=0; o_req_rdy=0; o_wdata_rdy=0; o_rdata_vld=0; o_rdata=0. Reset mid-burst aborts immediately: the next cycle shows the reset values, and no partial word is emitted.
- o_req_rdy=1 only in IDLE. It rises the cycle after reset deasserts (see optional feature).
- Byte address = {7'b0, addr, 1'b0}, 24 bits. The word's high byte is at the even byte, sent/received first.
- States: IDLE -> CMD(2) -> ADDR(6) -> [DUMMY(2), reads only] -> DATA(2 per word) -> END(1) -> IDLE.
- CMD: o_cs_n=0, o_sck_en=1, o_sio_oe=1, both sio = cmd[7:4] then cmd[3:0].
- ADDR: both sio = address nibbles, MSB first.
- DUMMY: o_sio_oe=0, o_sck_en=1.
- DATA: each cycle carries one byte.
  - Write: o_sio_hi = byte[7:4], o_sio_lo = byte[3:0].
  - Read: the byte is sampled as {i_sio_hi, i_sio_lo} at the edge ending each cycle.
- END: o_cs_n=1, o_sck_en=0, o_sio_oe=0.
- Write data handshake:
  - o_wdata_rdy=1 in the cycle before each word's first DATA cycle, i.e. the last ADDR cycle or the second byte cycle of the previous word.
  - On vld&rdy the word is latched. If vld=0 there, the next cycle is a stall.
  - Stall: state and counters hold, o_cs_n stays 0, o_sck_en=0, o_wdata_rdy stays 1 until vld.
- Read assembly: the first byte goes to a holding register. o_rdata_vld pulses the cycle after the second byte's cycle, with o_rdata = {byte0, byte1}.
  - For the last word, that pulse coincides with END.
- Word counter counts down from i_req_cnt. The burst ends after the word with counter=0. Maximum burst is 2^LEN_W words.
- Address wrap: only the starting address is sent and the memory auto-increments.
- A burst crossing word 16'hFFFF continues into byte 24'h020000 in the memory. No wrap is applied here.
- A new request is accepted no earlier than the IDLE cycle after END, so CS is high for at least 1 cycle between bursts.

Optional Feature:
Macro IDLI_SQI_SEQ_INIT_EN.
- Defined: after reset the block enters INIT before IDLE.
  - INIT issues EQIO (8'h38) in SPI mode: 8 cycles with o_cs_n=0, o_sck_en=1, o_sio_oe=1.
  - Bit i of the command, MSB first, is on sio[0] of both memories; sio[3:1]=0.
  - Then 1 END cycle, then IDLE. o_req_rdy first rises 10 cycles after reset deasserts.
- Undefined: no INIT state. IDLE, with o_req_rdy=1, is entered the cycle after reset deasserts.

Test Plan:
1. Read, addr=16'h1234, cnt=0; memory returns hi/lo nibbles 4'hA/4'hB then 4'hC/4'hD.
   -> Pins show CMD 0,3; ADDR 0,0,2,4,6,8; 2 dummy cycles; 2 data cycles.
   -> o_rdata_vld pulses once with o_rdata=16'hABCD; 13 cycles from accept to IDLE.
2. Write, addr=16'h0001, cnt=1, words 16'h5A3C and 16'hF00F with wdata always valid.
   -> CMD 0,2; ADDR 0,0,0,0,0,2; no dummy.
   -> o_sio_hi sequence 5,3,F,0 and o_sio_lo sequence A,C,0,F; o_wdata_rdy handshakes twice.
3. Same write with i_wdata_vld low for 3 cycles before word 2.
   -> 3 stall cycles: o_sck_en=0, o_cs_n=0, outputs held; the burst then completes with identical data.
4. Read burst cnt=15 -> 16 o_rdata_vld pulses, each 2 cycles apart, then o_cs_n=1 for at least 1 cycle before o_req_rdy.
5. Assert i_sqi_rst in the 3rd DATA cycle of a read -> next cycle all outputs at reset values, with no o_rdata_vld.
6. IDLI_SQI_SEQ_INIT_EN defined: after reset, sio_hi[0]/sio_lo[0] show 0,0,1,1,1,0,0,0 with o_cs_n=0, then o_cs_n=1, and o_req_rdy=1 on cycle 10.
